uart_rx_writer: RTL and testbench
=================================

// Module: uart_rx_writer
// PURPOSE
//  UART receiver, 8N1, LSB first; the stage downstream of uart_tx on the serial line.
//  Deserialises bytes from rx and writes each good byte into a byte memory.
//  The write side mirrors uart_tx's address/data read side: sequential addresses from 0,
//  and a '\0' byte terminates the string.
//  Used for loopback checks and for capturing host strings into on-chip RAM.
// PARAMETERS
//  CLKS_PER_BIT  8  clk cycles per bit; even, >=4; must match uart_tx
//  PARITY_ODD    0  1=odd, 0=even parity; used only when UART_RX_PARITY_EN is defined
// PORTS
//  clk         in   1  system clock; all logic on rising edge
//  rst         in   1  asynchronous, active-high reset
//  rx          in   1  serial line; idle high; asynchronous to clk
//  address     out  8  write address of the current/next byte
//  data        out  8  last received byte; held between writes
//  wr          out  1  one-cycle write strobe; address/data valid while high
//  done        out  1  one-cycle pulse with wr when the written byte is 8'h00
//  busy        out  1  high from start-bit detect until return to IDLE
//  frame_err   out  1  one-cycle pulse: stop bit sampled low
//  parity_err  out  1  one-cycle pulse: parity mismatch; tied 0 without macro
// BEHAVIOUR
//  - Reset: address=0, data=0, wr=done=busy=frame_err=parity_err=0, state=IDLE,
//    both sync FFs=1. Reset mid-frame drops the partial byte; no strobe is produced.
//  - rx passes through a 2-FF synchroniser (rx_s); all decisions use rx_s.
//  - Bit counter cnt counts 0..CLKS_PER_BIT-1. Bit index counts 0..7.
//  - FSM:
//    IDLE: rx_s==0 -> START, cnt=0, busy=1.
//    START: at cnt==CLKS_PER_BIT/2-1 sample. If rx_s==0 -> DATA, cnt=0.
//      Else (glitch) -> IDLE silently, no error.
//    DATA: at cnt==CLKS_PER_BIT-1 shift rx_s into shreg MSB (LSB-first), cnt=0.
//      After bit 7 -> PARITY (macro) or STOP.
//    PARITY: at cnt==CLKS_PER_BIT-1 sample. Record mismatch -> STOP.
//    STOP: at cnt==CLKS_PER_BIT-1 sample (stop-bit centre).
//      rx_s==1 and no parity mismatch -> next cycle wr=1, data=shreg.
//        done=1 if shreg==0. Then IDLE.
//      rx_s==1 with parity mismatch -> next cycle parity_err=1, no wr. Then IDLE.
//      rx_s==0 -> next cycle frame_err=1, no wr -> BREAK.
//    BREAK: wait for rx_s==1, then IDLE. A held-low line never retriggers START.
//  - Address: the cycle after wr, address<=address+1 (8-bit wrap 255->0).
//    If done, address<=0 instead. Errors leave address unchanged.
//  - busy drops in the cycle the FSM enters IDLE. data changes only with wr.
//  - Latency: wr is 1 cycle after the stop-bit centre sample.
//    The centre sample is ~2 sync cycles behind the line.
//  - Back-to-back frames: a new start bit seen in the IDLE cycle after STOP is accepted.
//    No idle gap is required beyond the stop bit's second half.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame is 8 data + 1 parity + 1 stop bit.
//    Parity is even (PARITY_ODD=0) or odd (PARITY_ODD=1).
//    A mismatch discards the byte and pulses parity_err.
//  Not defined: 8N1 only; PARITY state absent; parity_err tied 0.
// TESTING (CLKS_PER_BIT=8, line driven by bench bit-banger unless noted)
//  1. Reset, send 8'h48 -> one wr pulse with data=8'h48, address=0.
//     Then address=1, done=0, busy=0.
//  2. Send "Hi\0" back-to-back -> wr at addresses 0,1,2 with 8'h48,8'h69,8'h00.
//     done with third wr; address=0 afterwards.
//  3. Send 8'h55 with stop bit forced 0 for 16 cycles -> frame_err one pulse, no wr.
//     address unchanged; busy stays high until line high.
//  4. Low glitch of 3 cycles on idle line -> no wr/err; busy returns 0 within CLKS_PER_BIT.
//  5. Assert rst mid data bit 4 -> all outputs 0 immediately.
//     Next clean 8'hA5 is written at address 0.
//  6. Loopback with uart_tx sending "Hello, World!\0" -> 14 writes.
//     Captured bytes match the string; done on the last; address=0.
//  With UART_RX_PARITY_EN, PARITY_ODD=0: 8'h01 with parity bit 0 -> parity_err pulse, no wr.
//  With parity bit 1 -> wr, data=8'h01.

Source files
------------

// File: rtl/uart_rx_writer.sv
// 8N1 UART receiver that writes each good byte to sequential addresses from 0; a 0x00 byte ends the string.
// Define UART_RX_PARITY_EN to expect a parity bit (even, or odd with PARITY_ODD=1) before the stop bit.
module uart_rx_writer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] address,
    output logic [7:0] data,
    output logic       wr,
    output logic       done,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       address_q, address_d;
    logic [7:0]       data_q, data_d;
    logic             wr_q, wr_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             parity_err_q, parity_err_d;
    logic             par_bad_q, par_bad_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            address_q    <= '0;
            data_q       <= '0;
            wr_q         <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            address_q    <= address_d;
            data_q       <= data_d;
            wr_q         <= wr_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            par_bad_q    <= par_bad_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        data_d       = data_q;
        wr_d         = 1'b0;
        done_d       = 1'b0;
        busy_d       = busy_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        par_bad_d    = par_bad_q;
        address_d    = address_q;
        // Address advances the cycle after a write; the terminator rewinds it to 0.
        if (wr_q) begin
            address_d = done_q ? 8'd0 : address_q + 8'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    par_bad_d = 1'b0;
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = ((^shreg_q) ^ rx_s_q) != PARITY_ODD[0];
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        if (par_bad_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            wr_d   = 1'b1;
                            data_d = shreg_q;
                            done_d = (shreg_q == 8'h00);
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line must return high before another start bit is accepted.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign address   = address_q;
    assign data      = data_q;
    assign wr        = wr_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    logic [1:0] unused_parity;
    assign parity_err    = 1'b0;
    assign unused_parity = {PARITY_ODD[0], parity_err_q};
`endif

endmodule

// File: tb/tb_uart_rx_writer.sv
// Self-checking bench for uart_rx_writer (default 8N1 build): directed frames plus
// randomized byte streams, compared against a write-list model of the string capture.
module tb_uart_rx_writer;
   localparam int CPB = 8;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] byteVal;
      logic       isDone;
   } wrRec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] address;
   logic [7:0] data;
   logic       wr;
   logic       done;
   logic       busy;
   logic       frameErr;
   logic       parityErr;

   int total = 0;
   int bad = 0;
   int frameCnt = 0;
   int parityCnt = 0;
   int strayDone = 0;

   wrRec_t obsQ[$];
   wrRec_t expQ[$];
   logic [7:0] modelAddr;
   logic [7:0] modelData;
   string msg = "Hello, World!";

   uart_rx_writer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .address(address),
      .data(data),
      .wr(wr),
      .done(done),
      .busy(busy),
      .frame_err(frameErr),
      .parity_err(parityErr)
   );

   // Free-running 100 MHz-style clock.
   always #5 clk = ~clk;

   // Observe the write port and error pulses away from the active edge.
   always @(negedge clk) begin
      if (wr) obsQ.push_back({address, data, done});
      if (frameErr) frameCnt++;
      if (parityErr) parityCnt++;
      if (done && !wr) strayDone++;
   end

   // Safety net so a stuck run still ends with a visible failure.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drain both write lists and compare them entry by entry.
   task automatic checkWrites(input string tag);
      wrRec_t o;
      wrRec_t e;
      checkOutput({tag, " write count"}, obsQ.size(), expQ.size());
      while (obsQ.size() > 0 && expQ.size() > 0) begin
         o = obsQ.pop_front();
         e = expQ.pop_front();
         checkOutput({tag, " write {addr,data,done}"}, {15'd0, o}, {15'd0, e});
      end
      obsQ.delete();
      expQ.delete();
   endtask

   task automatic holdLine(input logic lvl, input int cycles);
      rx = lvl;
      repeat (cycles) @(negedge clk);
   endtask

   // Bit-bang one frame LSB first; stopLow>0 holds the stop bit low for that many cycles.
   task automatic applyStimulus(input logic [7:0] b, input int stopLow);
      holdLine(1'b0, CPB);
      for (int i = 0; i < 8; i++) holdLine(b[i], CPB);
      if (stopLow == 0) holdLine(1'b1, CPB);
      else holdLine(1'b0, stopLow);
   endtask

   // String-capture model: bytes land at consecutive addresses, the terminator rewinds to 0.
   task automatic expectWrite(input logic [7:0] b);
      expQ.push_back({modelAddr, b, (b == 8'h00)});
      modelAddr = (b == 8'h00) ? 8'h00 : modelAddr + 8'h01;
      modelData = b;
   endtask

   task automatic sendGood(input logic [7:0] b);
      applyStimulus(b, 0);
      expectWrite(b);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] a5;
      int gap;

      rst = 1'b1;
      rx = 1'b1;
      modelAddr = 8'h00;
      modelData = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("reset address", address, 0);
      checkOutput("reset data", data, 0);
      checkOutput("reset wr", wr, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset frame_err", frameErr, 0);
      checkOutput("reset parity_err", parityErr, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] single byte 0x48");
      sendGood(8'h48);
      holdLine(1'b1, 4);
      checkWrites("single");
      checkOutput("single address after", address, modelAddr);
      checkOutput("single done after", done, 0);
      checkOutput("single busy after", busy, 0);

      $display("[TB] back-to-back Hi\\0");
      sendGood(8'h48);
      sendGood(8'h69);
      sendGood(8'h00);
      holdLine(1'b1, 4);
      checkWrites("hi");
      checkOutput("hi address after", address, modelAddr);

      $display("[TB] stop bit held low");
      applyStimulus(8'h55, 16);
      checkOutput("break frame_err pulses", frameCnt, 1);
      checkOutput("break busy while low", busy, 1);
      holdLine(1'b1, 6);
      checkOutput("break busy after release", busy, 0);
      checkWrites("break");
      checkOutput("break address", address, modelAddr);
      checkOutput("break data held", data, modelData);

      $display("[TB] 3-cycle glitch");
      holdLine(1'b0, 3);
      holdLine(1'b1, CPB + 2);
      checkOutput("glitch busy", busy, 0);
      checkOutput("glitch frame_err pulses", frameCnt, 1);
      checkWrites("glitch");

      $display("[TB] randomized stream");
      for (int n = 0; n < 24; n++) begin
         b = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 5) == 0) b = 8'h00;
         gap = $urandom_range(0, 12);
         if (gap > 0) holdLine(1'b1, gap);
         sendGood(b);
      end
      holdLine(1'b1, 4);
      checkWrites("random");
      checkOutput("random address", address, modelAddr);
      checkOutput("random data", data, modelData);
      checkOutput("random frame_err pulses", frameCnt, 1);
      checkOutput("random parity_err pulses", parityCnt, 0);

      $display("[TB] reset during data bit 4");
      sendGood(8'($urandom_range(1, 255)));
      holdLine(1'b1, 4);
      checkWrites("prereset");
      a5 = 8'hA5;
      holdLine(1'b0, CPB);
      for (int i = 0; i < 4; i++) holdLine(a5[i], CPB);
      holdLine(a5[4], CPB / 2);
      checkOutput("midframe busy", busy, 1);
      rst = 1'b1;
      #1;
      checkOutput("midreset address", address, 0);
      checkOutput("midreset data", data, 0);
      checkOutput("midreset wr", wr, 0);
      checkOutput("midreset done", done, 0);
      checkOutput("midreset busy", busy, 0);
      checkOutput("midreset frame_err", frameErr, 0);
      rx = 1'b1;
      modelAddr = 8'h00;
      modelData = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      sendGood(8'hA5);
      holdLine(1'b1, 4);
      checkWrites("postreset");
      checkOutput("postreset address", address, modelAddr);

      $display("[TB] Hello, World! string");
      for (int i = 0; i < msg.len(); i++) sendGood(msg[i]);
      sendGood(8'h00);
      holdLine(1'b1, 4);
      checkWrites("hello");
      checkOutput("hello address", address, modelAddr);
      checkOutput("done only with wr", strayDone, 0);
      checkOutput("final frame_err pulses", frameCnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
